// File: rtl/dfifo_pkg.sv
// Shared types and defaults for the distributed-FIFO burst reader.
// Holds the state encoding and the burst-length decode helper.
package dfifo_pkg;

    localparam int DFIFO_DATA_WIDTH = 32;
    localparam int DFIFO_LEN_W      = 8;
    localparam int DFIFO_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dfifo_state_e;

    // A zero length field stands for the largest burst, 2^lw words.
    function automatic int unsigned dfifo_len_decode(
        input int unsigned len,
        input int unsigned lw
    );
        return (len == 0) ? (32'd1 << lw) : len;
    endfunction

endpackage

// File: rtl/dfifo_rd_skid_buf.sv
// Circular word buffer that absorbs FIFO read data still in flight.
// Write and read may coincide on a full buffer; the count then holds.
module dfifo_rd_skid_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DW-1:0]              wr_data_i,
    input  logic                       rd_en_i,
    output logic [DW-1:0]              rd_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_rd;
    logic          do_wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_rd = rd_en_i && (count_q != '0);
    assign do_wr = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/dfifo_burst_reader.sv
// Drains cmd_len words from a registered-read FIFO into a valid/ready stream.
// Define DFIFO_BURST_RD_STATS_EN to build the FIFO-starvation counter.
module dfifo_burst_reader
    import dfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DFIFO_DATA_WIDTH,
    parameter int LEN_W      = DFIFO_LEN_W,
    parameter int RD_LATENCY = DFIFO_RD_LATENCY,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic [15:0]           stall_cnt
);

    localparam int LCW = LEN_W + 1;
    localparam int IW  = $clog2(RD_LATENCY + 1);
    localparam int BCW = $clog2(BUF_DEPTH + 1);
    localparam int OW  = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    if (BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
        $error("BUF_DEPTH must be >= RD_LATENCY+2");
    end

    dfifo_state_e          state_q;
    logic [LCW-1:0]        len_q;
    logic [LCW-1:0]        issued_q;
    logic [LCW-1:0]        deliv_q;
    logic                  cmd_ready_q;
    logic                  done_q;
    logic [RD_LATENCY-1:0] pipe_q;
    logic [IW-1:0]         inflight;
    logic [BCW-1:0]        buf_cnt;
    logic [OW-1:0]         occ;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_empty;
    logic                  pop;
    logic                  accept;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + IW'(pipe_q[i]);
        end
    end

    // Reserve buffer room for every read still travelling through the pipe.
    assign occ        = OW'(inflight) + OW'(buf_cnt);
    assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty &&
                        (issued_q < len_q) && (occ < OW'(BUF_DEPTH));

    assign m_valid   = !buf_empty;
    assign m_data    = m_valid ? buf_data : '0;
    assign m_last    = m_valid && (deliv_q == len_q - LCW'(1));
    assign pop       = m_valid && m_ready;
    assign accept    = cmd_ready_q && cmd_valid;
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;

    dfifo_rd_skid_buf #(
        .DW    (DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (pipe_q[RD_LATENCY-1]),
        .wr_data_i (fifo_rd_data),
        .rd_en_i   (pop),
        .rd_data_o (buf_data),
        .empty_o   (buf_empty),
        .count_o   (buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            deliv_q     <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            pipe_q      <= '0;
        end else begin
            done_q <= 1'b0;
            pipe_q <= (pipe_q << 1) | RD_LATENCY'(fifo_rd_en);
            if (pop) deliv_q <= deliv_q + LCW'(1);
            unique case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= ST_RUN;
                        cmd_ready_q <= 1'b0;
                        len_q       <= LCW'(dfifo_len_decode(32'(cmd_len), LEN_W));
                        issued_q    <= '0;
                        deliv_q     <= '0;
                    end
                end
                ST_RUN: begin
                    if (fifo_rd_en) begin
                        issued_q <= issued_q + LCW'(1);
                        if (issued_q + LCW'(1) == len_q) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DFIFO_BURST_RD_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && (issued_q < len_q) &&
                     fifo_empty && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dfifo_burst_reader.sv
// Directed bench for dfifo_burst_reader with a 2-cycle registered FIFO model.
// Build with DFIFO_BURST_RD_STATS_EN to also check the starvation counter.
module tb_dfifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_ready;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          done;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    dfifo_burst_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .done         (done),
        .stall_cnt    (stall_cnt)
    );

    // FIFO model: data appears two cycles after the cycle with rd_en high.
    logic [DW-1:0] fmem [0:2047];
    int            wr_p = 0;
    int            rd_p = 0;
    logic [DW-1:0] s0 = '0;
    logic [DW-1:0] s1 = '0;

    assign fifo_empty   = (wr_p == rd_p);
    assign fifo_rd_data = s1;

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            s0   <= fmem[rd_p];
            rd_p <= rd_p + 1;
        end else begin
            s0 <= 32'hDEAD_BEEF;
        end
        s1 <= s0;
    end

    // m_ready either fixed or cycling through the pattern 1,0,0,1.
    bit   tog_en = 1'b0;
    bit   mr_fix = 1'b1;
    int   tcnt = 0;
    logic tpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clk) tcnt <= tcnt + 1;
    assign m_ready = tog_en ? tpat[tcnt % 4] : mr_fix;

    // Monitor
    bit            clr = 1'b0;
    logic [DW-1:0] got [$];
    int            lasts, last_idx, dones, issued, deliv, max_out, underflow;
    int            accepts;

    always @(negedge clk) begin
        if (clr) begin
            got.delete();
            lasts = 0; last_idx = 0; dones = 0;
            issued = 0; deliv = 0; max_out = 0; underflow = 0;
        end else begin
            if (fifo_rd_en && fifo_empty) underflow++;
            if (fifo_rd_en && (issued + 1 - deliv) > max_out)
                max_out = issued + 1 - deliv;
            if (fifo_rd_en) issued++;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                deliv++;
                if (m_last) begin
                    lasts++;
                    last_idx = got.size();
                end
            end
            if (done) dones++;
        end
    end

    always @(posedge clk) begin
        if (clr) accepts = 0;
        else if (cmd_valid && cmd_ready) accepts++;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fmem[wr_p] = v;
        wr_p++;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // Returns one ns into cycle 1 of the burst.
    task automatic start(input string nm, input int len);
        wait_idle(nm);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " done"}, 64'(done), 64'd1);
        #1;
    endtask

    task automatic chk_seq(input string nm, input logic [DW-1:0] base,
                           input int n);
        int bad = 0;
        chk({nm, " count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== base + DW'(i)) bad++;
        chk({nm, " order"}, 64'(bad), 64'd0);
        chk({nm, " one last"}, 64'(lasts), 64'd1);
        chk({nm, " last pos"}, 64'(last_idx), 64'(n));
    endtask

    typedef struct {
        int            cyc;
        bit            rd_en;
        bit            mv;
        bit            last;
        bit            dn;
        bit            crdy;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tv [13];

    initial begin
        int cyc_acc;
        int n;
        logic [15:0] exp_stall;

        for (int k = 1; k <= 13; k++) begin
            tv[k-1].cyc   = k;
            tv[k-1].rd_en = (k <= 8);
            tv[k-1].mv    = (k >= 4 && k <= 11);
            tv[k-1].last  = (k == 11);
            tv[k-1].dn    = (k == 12);
            tv[k-1].crdy  = (k >= 12);
            tv[k-1].data  = (k >= 4 && k <= 11) ? 32'h100 + DW'(k - 4) : '0;
        end

        // Reset behaviour
        repeat (2) @(negedge clk);
        chk("reset outputs",
            64'({cmd_ready, fifo_rd_en, m_valid, m_last, done, stall_cnt, m_data}),
            64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready low in release cycle", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("cmd_ready first cycle after reset", 64'(cmd_ready), 64'd1);

        // Test 1: cycle-exact 8-word burst
        clear_mon();
        for (int i = 0; i < 8; i++) push(32'h100 + DW'(i));
        start("t1", 8);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("t1 cycle %0d", tv[i].cyc),
                64'({fifo_rd_en, m_valid, m_last, done, cmd_ready,
                     (tv[i].mv ? m_data : 32'h0)}),
                64'({tv[i].rd_en, tv[i].mv, tv[i].last, tv[i].dn, tv[i].crdy,
                     tv[i].data}));
        end

        // Test 2: m_ready back-pressure 1,0,0,1
        clear_mon();
        for (int i = 0; i < 8; i++) push(32'h200 + DW'(i));
        tog_en = 1'b1;
        start("t2", 8);
        wait_done("t2", 200);
        tog_en = 1'b0;
        chk_seq("t2", 32'h200, 8);
        chk("t2 outstanding <= 4", 64'(max_out <= 4), 64'd1);

        // Test 3: FIFO starves for 10 cycles mid-burst
        clear_mon();
        for (int i = 0; i < 3; i++) push(32'h300 + DW'(i));
        start("t3", 6);
        repeat (13) @(posedge clk);
        #1;
        for (int i = 3; i < 6; i++) push(32'h300 + DW'(i));
        wait_done("t3", 100);
        chk_seq("t3", 32'h300, 6);
        chk("t3 no underflow", 64'(underflow), 64'd0);
`ifdef DFIFO_BURST_RD_STATS_EN
        exp_stall = 16'd10;
`else
        exp_stall = 16'd0;
`endif
        chk("t3 stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        repeat (3) @(posedge clk);
        #1;
        chk("t3 stall_cnt holds", 64'(stall_cnt), 64'(exp_stall));

        // Test 4: cmd_len=0 means 256 words
        clear_mon();
        for (int i = 0; i < 256; i++) push(32'h1000 + DW'(i));
        start("t4", 0);
        chk("t4 stall cleared on accept", 64'(stall_cnt), 64'd0);
        wait_done("t4", 600);
        chk_seq("t4", 32'h1000, 256);
        chk("t4 no underflow", 64'(underflow), 64'd0);

        // Test 5: reset for one cycle in DRAIN
        clear_mon();
        for (int i = 0; i < 8; i++) push(32'h500 + DW'(i));
        start("t5", 8);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5 outputs after reset",
            64'({cmd_ready, fifo_rd_en, m_valid, m_last, done, stall_cnt, m_data}),
            64'd0);
        @(negedge clk);
        chk("t5 cmd_ready after release", 64'({cmd_ready, done, m_valid}),
            64'b100);
        #1;
        chk("t5 no done pulse", 64'(dones), 64'd0);
        clear_mon();
        push(32'h5A5A);
        start("t5b", 1);
        wait_done("t5b", 50);
        chk_seq("t5b", 32'h5A5A, 1);
        chk("t5b one done", 64'(dones), 64'd0 + 64'(dones == 1 ? 1 : 99));

        // Test 6: cmd_valid held through the burst
        clear_mon();
        for (int i = 0; i < 8; i++) push(32'h600 + DW'(i));
        wait_idle("t6");
        cmd_valid = 1'b1;
        cmd_len   = LW'(4);
        cyc_acc   = 0;
        n         = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        chk("t6 second accept cycle", 64'(n), 64'd8);
        chk("t6 done with re-accept", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done("t6b", 50);
        chk("t6 accepts", 64'(accepts), 64'd2);
        chk("t6 words", 64'(got.size()), 64'd8);
        chk("t6 final word", 64'(got.size() == 8 ? got[7] : 32'h0),
            64'h607);
        chk("t6 lasts", 64'(lasts), 64'd2);
        cyc_acc = n;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
